// File: rtl/fetch_align_if.sv
// Bundles the instruction-memory, redirect and issue-side signals of the fetch realignment stage.
interface fetch_align_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        is_compressed;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, is_compressed,
    input  imem_data, imem_valid, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, is_compressed,
    output imem_data, imem_valid, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_align.sv
// Fetch realignment: buffers aligned memory words as halfwords and issues one
// 16- or 32-bit instruction per handshake, handling halfword-aligned redirects.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk_i,
  input logic         rst_n_i,
  fetch_align_if.master bus
);

  logic [15:0] hw_q [4];
  logic [1:0]  head;
  logic [2:0]  count;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic        outstanding;
  logic        skip;
  logic        drop;

  logic [15:0] head_hw;
  logic [15:0] next_hw;
  logic        head_is_c;
  logic        consume;
  logic        accept;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [1:0]  tail;

  // Decode the queue head and decide what this cycle pops and pushes.
  always_comb begin
    head_hw   = hw_q[head];
    next_hw   = hw_q[head + 2'd1];
    head_is_c = (head_hw[1:0] != 2'b11);
    tail      = head + count[1:0];

    bus.instr_valid   = !bus.redirect && (((count >= 3'd1) && head_is_c) || (count >= 3'd2));
    bus.is_compressed = (count != 3'd0) && head_is_c;
    bus.instr_pc      = pc;
    bus.instr         = 32'h0;
    if (bus.instr_valid) begin
      bus.instr = head_is_c ? {16'h0000, head_hw} : {next_hw, head_hw};
    end

    // Requests are gated in reset too, since the register state alone would allow one.
    bus.imem_req  = rst_n_i && !outstanding && (count <= 3'd2) && !bus.redirect;
    bus.imem_addr = fetch_addr;

    consume = bus.instr_valid && !bus.stall;
    pop_n   = 3'd0;
    if (consume) begin
      pop_n = head_is_c ? 3'd1 : 3'd2;
    end

    accept = bus.imem_valid && !drop && !bus.redirect;
    push_n = 3'd0;
    if (accept) begin
      push_n = skip ? 3'd1 : 3'd2;
    end
  end

  // Control state; a redirect overrides every other update in its cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head        <= 2'd0;
      count       <= 3'd0;
      pc          <= RESET_PC;
      fetch_addr  <= {RESET_PC[31:2], 2'b00};
      skip        <= RESET_PC[1];
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (bus.redirect) begin
      count      <= 3'd0;
      pc         <= {bus.redirect_pc[31:1], 1'b0};
      fetch_addr <= {bus.redirect_pc[31:2], 2'b00};
      skip       <= bus.redirect_pc[1];
      if (bus.imem_valid) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end else begin
        drop <= outstanding;
      end
    end else begin
      head  <= head + pop_n[1:0];
      count <= count - pop_n + push_n;
      if (consume) begin
        pc <= pc + {28'd0, pop_n, 1'b0};
      end
      if (bus.imem_valid) begin
        outstanding <= 1'b0;
        if (drop) begin
          drop <= 1'b0;
        end else begin
          skip <= 1'b0;
        end
      end
      if (bus.imem_req) begin
        outstanding <= 1'b1;
        fetch_addr  <= fetch_addr + 32'd4;
      end
    end
  end

  // Halfword storage; slots past the tail are free because requests stop at count>2.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (skip) begin
        hw_q[tail] <= bus.imem_data[31:16];
      end else begin
        hw_q[tail]         <= bus.imem_data[15:0];
        hw_q[tail + 2'd1]  <= bus.imem_data[31:16];
      end
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Randomized scoreboard bench for fetch_align: a memory model feeds words, and
// expected instructions are derived by walking the memory image from the PC.
module tb_fetch_align;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_align_if bus ();

  fetch_align #(.RESET_PC(RESET_PC)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  exp_t        exp_q [$];
  logic [31:0] model_pc;
  logic [31:0] exp_fetch;
  int          checks = 0;
  int          passed = 0;
  int          consumed = 0;

  logic        req_seen;
  logic [31:0] addr_seen;
  logic        pend = 1'b0;
  int          pend_wait;
  logic [31:0] pend_addr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // The instruction stream is just the memory image walked by length from the PC.
  task automatic topUp();
    exp_t        e;
    logic [15:0] h;
    while (exp_q.size() < 4) begin
      h    = hw_at(model_pc);
      e.pc = model_pc;
      if (h[1:0] != 2'b11) begin
        e.instr  = {16'h0000, h};
        e.c      = 1'b1;
        model_pc = model_pc + 32'd2;
      end else begin
        e.instr  = {hw_at(model_pc + 32'd2), h};
        e.c      = 1'b0;
        model_pc = model_pc + 32'd4;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic restartModel(input logic [31:0] target);
    exp_q.delete();
    model_pc  = {target[31:1], 1'b0};
    exp_fetch = {target[31:2], 2'b00};
    topUp();
  endtask

  // One clock of stimulus: memory model, random redirect and stall.
  // stall_mode: 0 none, 1 random, 2 forced.
  task automatic applyStimulus(input bit allow_redirect, input int stall_mode);
    logic [31:0] target;
    @(negedge clk);
    req_seen  = bus.imem_req;
    addr_seen = bus.imem_addr;
    if (req_seen) begin
      checkOutput("imem_addr", addr_seen, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    #1;
    if (req_seen) begin
      pend      = 1'b1;
      pend_wait = $urandom_range(0, 2);
      pend_addr = addr_seen;
    end
    bus.imem_valid = 1'b0;
    bus.imem_data  = $urandom;
    if (pend) begin
      if (pend_wait == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_data  = mem[pend_addr[7:2]];
        pend           = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    bus.redirect = 1'b0;
    if (allow_redirect && ($urandom_range(0, 24) == 0)) begin
      target          = $urandom_range(0, 255);
      bus.redirect    = 1'b1;
      bus.redirect_pc = target;
      restartModel(target);
    end
    case (stall_mode)
      1:       bus.stall = ($urandom_range(0, 3) == 0);
      2:       bus.stall = 1'b1;
      default: bus.stall = 1'b0;
    endcase
    topUp();
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    checkOutput("rst_instr", bus.instr, 32'd0);
    checkOutput("rst_instr_pc", bus.instr_pc, RESET_PC);
    checkOutput("rst_is_compressed", {31'd0, bus.is_compressed}, 32'd0);
  endtask

  // Monitor: every presented instruction must match the head of the expected stream.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("queue_le4", {31'd0, (dut.count <= 3'd4)}, 32'd1);
      if (bus.instr_valid) begin
        checkOutput("exp_available", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          checkOutput("instr", bus.instr, exp_q[0].instr);
          checkOutput("instr_pc", bus.instr_pc, exp_q[0].pc);
          checkOutput("is_compressed", {31'd0, bus.is_compressed}, {31'd0, exp_q[0].c});
          if (!bus.stall) begin
            void'(exp_q.pop_front());
            consumed++;
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
    end
    mem[0] = 32'h0041_0113;
    mem[1] = 32'h4505_4505;
    mem[2] = {16'h0113, 16'h4505};
    mem[3] = {16'h1234, 16'h0041};

    bus.imem_valid  = 1'b0;
    bus.imem_data   = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.stall       = 1'b0;
    model_pc        = RESET_PC;
    exp_fetch       = RESET_PC;

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    rst_n = 1'b1;
    restartModel(RESET_PC);

    repeat (16) applyStimulus(1'b0, 0);
    repeat (5) applyStimulus(1'b0, 2);
    repeat (1500) applyStimulus(1'b1, 1);
    repeat (6) applyStimulus(1'b0, 2);
    repeat (1000) applyStimulus(1'b1, 1);

    for (int i = 0; i < 50 && !pend; i++) begin
      applyStimulus(1'b0, 0);
    end
    checkOutput("pending_before_reset", {31'd0, pend}, 32'd1);
    rst_n        = 1'b0;
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    #1;
    checkResetOutputs();
    repeat (5) applyStimulus(1'b0, 0);
    checkResetOutputs();
    bus.imem_valid = 1'b0;
    pend           = 1'b0;
    rst_n          = 1'b1;
    restartModel(RESET_PC);

    repeat (600) applyStimulus(1'b1, 1);

    checkOutput("progress", {31'd0, (consumed >= 200)}, 32'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
